uart_sdram_bridge: RTL
======================

// Module: uart_sdram_bridge
// PURPOSE
//  Command front-end between the UART byte link and the SDRAM controller. Assembles
//  host byte packets into single 16-bit read/write requests on the controller's
//  addr/rd_req/wr_req/wr_data port and returns read data or an ack byte to the UART
//  transmitter. One transaction in flight at a time; sits directly upstream of the
//  SDRAM controller.
// PARAMETERS
//  GAP_TIMEOUT  50_000  max clk cycles between bytes of one packet before abort to IDLE
//  REQ_TIMEOUT  1_000   max clk cycles waiting for mem_*_ready before abort with error
//  ACK_BYTE     8'h4B   byte sent after a completed write ('K')
//  ERR_BYTE     8'h45   byte sent on request timeout ('E')
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous, active-low reset
//  rx_data       in   8   received UART byte
//  rx_valid      in   1   1-cycle strobe, rx_data valid; no backpressure
//  tx_data       out  8   byte to transmit
//  tx_valid      out  1   tx_data valid; held until accepted
//  tx_ready      in   1   transmitter accepts on tx_valid && tx_ready
//  mem_addr      out  24  word address {bank[23:22], row[21:9], col[8:0]}
//  mem_wr_req    out  1   write request level, held until mem_wr_ready
//  mem_rd_req    out  1   read request level, held until mem_rd_ready
//  mem_wr_data   out  16  write data
//  mem_rd_data   in   16  read data, valid on mem_rd_ready
//  mem_wr_ready  in   1   1-cycle write-complete pulse
//  mem_rd_ready  in   1   1-cycle read-complete pulse
//  busy          out  1   high in every state except IDLE
//  rx_overrun    out  1   1-cycle pulse when an rx byte is dropped
// BEHAVIOUR
//  Reset: state=IDLE; tx_data=0, tx_valid=0, mem_addr=0, mem_wr_data=0, mem_wr_req=0,
//   mem_rd_req=0, busy=0, rx_overrun=0; byte counter and timers cleared. Reset mid-
//   transaction drops requests immediately; no partial packet survives.
//  Packets (multi-byte fields MSB first): write = 8'h57 A2 A1 A0 D1 D0 -> ACK_BYTE;
//   read = 8'h52 A2 A1 A0 -> D1 D0 (mem_rd_data[15:8] then [7:0]).
//  States: IDLE, RX_ADDR, RX_DATA, WR_REQ, RD_REQ, TX_ACK, TX_HI, TX_LO, TX_ERR.
//  IDLE: rx 8'h57 -> RX_ADDR (op=wr); 8'h52 -> RX_ADDR (op=rd); other bytes ignored,
//   no response, no overrun.
//  RX_ADDR: shift 3 bytes into mem_addr; after 3rd: op=wr -> RX_DATA, op=rd -> RD_REQ.
//  RX_DATA: shift 2 bytes into mem_wr_data; after 2nd -> WR_REQ.
//  Gap timer clears on each accepted byte; reaching GAP_TIMEOUT in RX_ADDR/RX_DATA
//   -> IDLE, no response, requests never raised.
//  WR_REQ/RD_REQ: request asserted the cycle after the final packet byte's rx_valid;
//   held high until ready sampled; deasserted the cycle after ready pulse.
//   mem_addr/mem_wr_data stable for whole request. mem_rd_data captured on the
//   mem_rd_ready cycle. wr -> TX_ACK, rd -> TX_HI. Ready pulse of the other type is
//   ignored.
//  REQ_TIMEOUT cycles without ready: drop request, -> TX_ERR. A ready arriving the
//   same cycle the timer expires counts as success.
//  TX_*: tx_valid=1 with byte; advance on tx_valid && tx_ready (TX_HI -> TX_LO;
//   TX_LO/TX_ACK/TX_ERR -> IDLE). tx_data stable while tx_valid high.
//  rx_valid in WR_REQ, RD_REQ or any TX_* state: byte dropped, rx_overrun=1 next cycle.
//  Return to IDLE takes effect the cycle after the final tx handshake; a byte arriving
//   on that handshake cycle is dropped (overrun).
// TESTING
//  1. rx 57 01 23 45 BE EF -> mem_addr=24'h012345, mem_wr_data=16'hBEEF, mem_wr_req high
//     until mem_wr_ready; then tx 8'h4B.
//  2. rx 52 01 23 45; drive mem_rd_data=16'hCAFE with mem_rd_ready after 5 cycles
//     -> mem_rd_req high 5 cycles; tx 8'hCA then 8'hFE.
//  3. rx 57 00 00 then idle GAP_TIMEOUT cycles -> back to IDLE, busy=0, no request, no tx.
//  4. rx 52 00 00 10, never pulse ready -> mem_rd_req drops after REQ_TIMEOUT; tx 8'h45.
//  5. Hold tx_ready=0 during read response, send rx byte -> rx_overrun pulse, tx_valid
//     held with 8'hCA stable; release tx_ready -> both bytes sent, returns to IDLE.
//  6. rx 8'h41 then 57 ... packet -> 8'h41 ignored, write proceeds; assert rst_n low
//     during WR_REQ -> mem_wr_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/uart_sdram_bridge.sv
// UART byte-packet to SDRAM request bridge.
// One 16-bit read or write in flight; replies with data, ack or error byte.
module uart_sdram_bridge #(
  parameter int          GAP_TIMEOUT = 50_000,
  parameter int          REQ_TIMEOUT = 1_000,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  ERR_BYTE    = 8'h45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] mem_addr,
  output logic        mem_wr_req,
  output logic        mem_rd_req,
  output logic [15:0] mem_wr_data,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_wr_ready,
  input  logic        mem_rd_ready,
  output logic        busy,
  output logic        rx_overrun
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RX_ADDR = 4'd1;
  localparam logic [3:0] S_RX_DATA = 4'd2;
  localparam logic [3:0] S_WR_REQ  = 4'd3;
  localparam logic [3:0] S_RD_REQ  = 4'd4;
  localparam logic [3:0] S_TX_ACK  = 4'd5;
  localparam logic [3:0] S_TX_HI   = 4'd6;
  localparam logic [3:0] S_TX_LO   = 4'd7;
  localparam logic [3:0] S_TX_ERR  = 4'd8;

  localparam int TMAX = (GAP_TIMEOUT > REQ_TIMEOUT) ? GAP_TIMEOUT : REQ_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TIMEOUT - 1);
  localparam logic [TW-1:0] REQ_LAST = TW'(REQ_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic          op_wr_q, op_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    txd_q, txd_d;
  logic          ovr_q, ovr_d;
  logic          rx_open;

  assign rx_open = (state_q == S_IDLE) || (state_q == S_RX_ADDR)
                || (state_q == S_RX_DATA);

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    lo_d    = lo_q;
    txd_d   = txd_q;
    ovr_d   = rx_valid && !rx_open;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        tmr_d = '0;
        if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) begin
          op_wr_d = (rx_data == 8'h57);
          state_d = S_RX_ADDR;
        end
      end
      S_RX_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[15:0], rx_data};
          tmr_d  = '0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = op_wr_q ? S_RX_DATA : S_RD_REQ;
          end
        end else if (tmr_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RX_DATA: begin
        if (rx_valid) begin
          wdat_d = {wdat_q[7:0], rx_data};
          tmr_d  = '0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = S_WR_REQ;
          end
        end else if (tmr_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      // A ready landing on the expiry cycle wins over the timeout.
      S_WR_REQ: begin
        if (mem_wr_ready) begin
          txd_d   = ACK_BYTE;
          state_d = S_TX_ACK;
        end else if (tmr_q == REQ_LAST) begin
          txd_d   = ERR_BYTE;
          state_d = S_TX_ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (mem_rd_ready) begin
          txd_d   = mem_rd_data[15:8];
          lo_d    = mem_rd_data[7:0];
          state_d = S_TX_HI;
        end else if (tmr_q == REQ_LAST) begin
          txd_d   = ERR_BYTE;
          state_d = S_TX_ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_TX_HI: begin
        if (tx_ready) begin
          txd_d   = lo_q;
          state_d = S_TX_LO;
        end
      end
      S_TX_LO, S_TX_ACK, S_TX_ERR: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= 2'd0;
      tmr_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      lo_q    <= '0;
      txd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      lo_q    <= lo_d;
      txd_q   <= txd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_data = wdat_q;
  assign mem_wr_req  = (state_q == S_WR_REQ);
  assign mem_rd_req  = (state_q == S_RD_REQ);
  assign tx_data     = txd_q;
  assign tx_valid    = (state_q == S_TX_ACK) || (state_q == S_TX_HI)
                    || (state_q == S_TX_LO)  || (state_q == S_TX_ERR);
  assign busy        = (state_q != S_IDLE);
  assign rx_overrun  = ovr_q;

endmodule
